// File: rtl/mbi_seq_pkg.sv
// Shared types and constants for the exposure sequencer.
// State encoding, bus widths and output reset values.
package mbi_seq_pkg;

  localparam int PHASE_W = 5;
  localparam int DUTY_W  = 4;
  localparam int SUB_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SETTLE,
    EXPOSE,
    READOUT
  } seq_state_e;

  localparam logic               RST_DRAIN_B = 1'b0;
  localparam logic [PHASE_W-1:0] RST_PHASE   = '0;
  localparam logic [DUTY_W-1:0]  RST_DUTY    = '0;
  localparam logic [SUB_W-1:0]   RST_SUB     = '0;
  localparam logic               RST_REQ     = 1'b0;
  localparam logic               RST_BUSY    = 1'b0;
  localparam logic               RST_DONE    = 1'b0;

endpackage

// File: rtl/mbi_seq_timer.sv
// Loadable down-counter shared by the drain, settle and expose phases.
// DONE is high during the Nth cycle after a load of N (N >= 1).
module mbi_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK_IN,
  input  logic             RST_B,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] VALUE,
  output logic             DONE
);

  logic [WIDTH-1:0] cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge CLK_IN) begin
    if (!RST_B) begin
      cnt <= '0;
    end else if (LOAD) begin
      cnt <= VALUE;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign DONE = (cnt == WIDTH'(1));

endmodule

// File: rtl/mod_exposure_sequencer.sv
// Frame/subframe sequencer driving DRAIN_B, PHASE_SEL, DUTY_SEL.
// Define SEQ_CONTINUOUS_EN for free-running back-to-back frames.
module mod_exposure_sequencer
  import mbi_seq_pkg::*;
#(
  parameter int PERIOD_LOG2   = 17,
  parameter int EXP_W         = 16,
  parameter int MAX_SUB       = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       CLK_IN,
  input  logic                       RST_B,
  input  logic                       START,
  input  logic                       ABORT,
  input  logic [$clog2(MAX_SUB)-1:0] NUM_SUBFRAMES,
  input  logic [EXP_W-1:0]           EXP_PERIODS,
  input  logic [EXP_W-1:0]           DRAIN_CYCLES,
  input  logic [PHASE_W-1:0]         PHASE_BASE,
  input  logic [PHASE_W-1:0]         PHASE_STEP,
  input  logic [DUTY_W-1:0]          DUTY_IN,
  input  logic                       READOUT_ACK,
  output logic                       DRAIN_B,
  output logic [PHASE_W-1:0]         PHASE_SEL,
  output logic [DUTY_W-1:0]          DUTY_SEL,
  output logic                       READOUT_REQ,
  output logic [SUB_W-1:0]           SUBFRAME_IDX,
  output logic                       BUSY,
  output logic                       FRAME_DONE
);

  localparam int TW = EXP_W + PERIOD_LOG2;

`ifdef SEQ_CONTINUOUS_EN
  localparam logic CONT = 1'b1;
`else
  localparam logic CONT = 1'b0;
`endif

  seq_state_e st, ns;

  logic [$clog2(MAX_SUB)-1:0] nsub_q;
  logic [EXP_W-1:0]           exp_q;
  logic [EXP_W-1:0]           drain_q;
  logic [PHASE_W-1:0]         step_q;
  logic [EXP_W-1:0]           exp_in;
  logic [EXP_W-1:0]           drain_in;

  logic          last;
  logic          new_frame;
  logic          tmr_load;
  logic          tmr_done;
  logic [TW-1:0] tmr_val;

  logic               drain_b_d;
  logic [PHASE_W-1:0] phase_d;
  logic [DUTY_W-1:0]  duty_d;
  logic               req_d;
  logic [SUB_W-1:0]   idx_d;
  logic               busy_d;
  logic               fdone_d;

  assign exp_in   = (EXP_PERIODS == '0) ? EXP_W'(1) : EXP_PERIODS;
  assign drain_in = (DRAIN_CYCLES == '0) ? EXP_W'(1) : DRAIN_CYCLES;
  assign last     = (SUBFRAME_IDX == nsub_q);

  // A new frame begins on START from idle, or at wrap in free-run.
  assign new_frame = (st == IDLE && START) ||
                     (CONT && st == READOUT && READOUT_ACK && last);

  // State register.
  always_ff @(posedge CLK_IN) begin
    if (!RST_B) st <= IDLE;
    else        st <= ns;
  end

  // Next-state logic; ABORT overrides everything.
  always_comb begin
    ns = st;
    case (st)
      IDLE:    if (START)       ns = DRAIN;
      DRAIN:   if (tmr_done)    ns = SETTLE;
      SETTLE:  if (tmr_done)    ns = EXPOSE;
      EXPOSE:  if (tmr_done)    ns = READOUT;
      READOUT: if (READOUT_ACK) ns = (last && !CONT) ? IDLE : DRAIN;
      default:                  ns = IDLE;
    endcase
    if (ABORT) ns = IDLE;
  end

  // Reload the shared timer with the length of the state being entered.
  always_comb begin
    tmr_val = '0;
    case (ns)
      DRAIN:   tmr_val = TW'(new_frame ? drain_in : drain_q);
      SETTLE:  tmr_val = TW'(SETTLE_CYCLES);
      EXPOSE:  tmr_val = TW'(exp_q) << PERIOD_LOG2;
      default: tmr_val = '0;
    endcase
  end

  assign tmr_load = (ns != st);

  mbi_seq_timer #(
    .WIDTH(TW)
  ) u_timer (
    .CLK_IN(CLK_IN),
    .RST_B (RST_B),
    .LOAD  (tmr_load),
    .VALUE (tmr_val),
    .DONE  (tmr_done)
  );

  // Next output values, derived from the state being entered.
  always_comb begin
    drain_b_d = (ns == EXPOSE);
    busy_d    = (ns != IDLE);
    req_d     = (ns == READOUT);
    fdone_d   = !ABORT && st == READOUT && READOUT_ACK && last;
    phase_d   = PHASE_SEL;
    duty_d    = DUTY_SEL;
    idx_d     = SUBFRAME_IDX;
    if (!ABORT) begin
      if (new_frame) begin
        phase_d = PHASE_BASE;
        duty_d  = DUTY_IN;
        idx_d   = '0;
      end else if (st == READOUT && READOUT_ACK && !last) begin
        phase_d = PHASE_SEL + step_q;
        idx_d   = SUBFRAME_IDX + SUB_W'(1);
      end
    end
  end

  // Output registers.
  always_ff @(posedge CLK_IN) begin
    if (!RST_B) begin
      DRAIN_B      <= RST_DRAIN_B;
      PHASE_SEL    <= RST_PHASE;
      DUTY_SEL     <= RST_DUTY;
      READOUT_REQ  <= RST_REQ;
      SUBFRAME_IDX <= RST_SUB;
      BUSY         <= RST_BUSY;
      FRAME_DONE   <= RST_DONE;
    end else begin
      DRAIN_B      <= drain_b_d;
      PHASE_SEL    <= phase_d;
      DUTY_SEL     <= duty_d;
      READOUT_REQ  <= req_d;
      SUBFRAME_IDX <= idx_d;
      BUSY         <= busy_d;
      FRAME_DONE   <= fdone_d;
    end
  end

  // Capture frame configuration at each frame boundary.
  always_ff @(posedge CLK_IN) begin
    if (!RST_B) begin
      nsub_q  <= '0;
      exp_q   <= '0;
      drain_q <= '0;
      step_q  <= '0;
    end else if (new_frame && !ABORT) begin
      nsub_q  <= NUM_SUBFRAMES;
      exp_q   <= exp_in;
      drain_q <= drain_in;
      step_q  <= PHASE_STEP;
    end
  end

endmodule

// File: tb/tb_mod_exposure_sequencer.sv
// Self-checking bench for mod_exposure_sequencer.
// Frame table plus abort/reset/free-run sequences.
module tb_mod_exposure_sequencer;

  logic        CLK_IN = 1'b0;
  logic        RST_B = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [2:0]  NUM_SUBFRAMES = '0;
  logic [15:0] EXP_PERIODS = '0;
  logic [15:0] DRAIN_CYCLES = '0;
  logic [4:0]  PHASE_BASE = '0;
  logic [4:0]  PHASE_STEP = '0;
  logic [3:0]  DUTY_IN = '0;
  logic        READOUT_ACK = 1'b0;
  logic        DRAIN_B;
  logic [4:0]  PHASE_SEL;
  logic [3:0]  DUTY_SEL;
  logic        READOUT_REQ;
  logic [2:0]  SUBFRAME_IDX;
  logic        BUSY;
  logic        FRAME_DONE;

  mod_exposure_sequencer #(
    .PERIOD_LOG2  (4),
    .EXP_W        (16),
    .MAX_SUB      (8),
    .SETTLE_CYCLES(4)
  ) dut (
    .CLK_IN       (CLK_IN),
    .RST_B        (RST_B),
    .START        (START),
    .ABORT        (ABORT),
    .NUM_SUBFRAMES(NUM_SUBFRAMES),
    .EXP_PERIODS  (EXP_PERIODS),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .PHASE_BASE   (PHASE_BASE),
    .PHASE_STEP   (PHASE_STEP),
    .DUTY_IN      (DUTY_IN),
    .READOUT_ACK  (READOUT_ACK),
    .DRAIN_B      (DRAIN_B),
    .PHASE_SEL    (PHASE_SEL),
    .DUTY_SEL     (DUTY_SEL),
    .READOUT_REQ  (READOUT_REQ),
    .SUBFRAME_IDX (SUBFRAME_IDX),
    .BUSY         (BUSY),
    .FRAME_DONE   (FRAME_DONE)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    int nsub;
    int expp;
    int drain;
    int base;
    int step;
    int duty;
    int dly;
    bit ack_exp;
    int exp_len;
    int low_len;
  } vec_t;

  typedef struct {
    int idx;
    int phase;
    int exp_len;
    int low_len;
  } sb_t;

  sb_t q[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply_cfg(input vec_t v);
    NUM_SUBFRAMES = 3'(v.nsub);
    EXP_PERIODS   = 16'(v.expp);
    DRAIN_CYCLES  = 16'(v.drain);
    PHASE_BASE    = 5'(v.base);
    PHASE_STEP    = 5'(v.step);
    DUTY_IN       = 4'(v.duty);
  endtask

  task automatic scramble();
    NUM_SUBFRAMES = 3'($urandom);
    EXP_PERIODS   = 16'($urandom_range(200, 900));
    DRAIN_CYCLES  = 16'($urandom_range(30, 90));
    PHASE_BASE    = 5'($urandom);
    PHASE_STEP    = 5'($urandom);
    DUTY_IN       = 4'($urandom);
  endtask

  task automatic run_frame(input vec_t v);
    logic [4:0] p;
    logic [4:0] req_ph;
    sb_t e;
    int  hi, lo, viol, ackcnt;
    bit  acked, done_seen, prev_req;
    hi = 0; lo = 0; viol = 0; ackcnt = 0;
    acked = 0; done_seen = 0; prev_req = 0;
    req_ph = '0;
    q.delete();
    p = 5'(v.base);
    for (int k = 0; k <= v.nsub; k++) begin
      q.push_back('{k, int'(p), v.exp_len, v.low_len});
      p = p + 5'(v.step);
    end
    apply_cfg(v);
    START = 1'b1;
    @(negedge CLK_IN);
    START = 1'b0;
    scramble();
    check("duty_sel", DUTY_SEL, v.duty);
    for (int c = 0; c < 5000 && !done_seen; c++) begin
      if (c > 0) @(negedge CLK_IN);
      READOUT_ACK = 1'b0;
      if (acked) begin
        acked = 0;
        check("req_drop", READOUT_REQ, 0);
        if (q.size() == 0) begin
          check("frame_done", FRAME_DONE, 1);
          check("busy_end", BUSY, 0);
          done_seen = 1;
          continue;
        end
      end
      if (FRAME_DONE) viol++;
      if (DRAIN_B) hi++;
      else if (!READOUT_REQ) lo++;
      if (READOUT_REQ && !prev_req) begin
        if (q.size() == 0) begin
          check("sb_extra_sub", 1, 0);
        end else begin
          e = q.pop_front();
          check("sub_idx", SUBFRAME_IDX, e.idx);
          check("phase_sel", PHASE_SEL, e.phase);
          check("expose_len", hi, e.exp_len);
          check("drain_len", lo, e.low_len);
        end
        hi = 0;
        lo = 0;
        req_ph = PHASE_SEL;
        ackcnt = v.dly;
      end
      if (READOUT_REQ) begin
        if (DRAIN_B || PHASE_SEL != req_ph) viol++;
        if (ackcnt == 0) begin
          READOUT_ACK = 1'b1;
          acked = 1;
        end else begin
          ackcnt--;
        end
      end
      if (v.ack_exp && DRAIN_B && hi == 3) READOUT_ACK = 1'b1;
      prev_req = READOUT_REQ;
    end
    READOUT_ACK = 1'b0;
    check("frame_complete", done_seen, 1);
    check("frame_viol", viol, 0);
    @(negedge CLK_IN);
    check("done_one_cycle", FRAME_DONE, 0);
  endtask

  vec_t tbl[4];

  initial begin
    int  viol;
    bit  found;
    int  dones, drops, ph2;
    vec_t cv;

    tbl[0] = '{2, 2, 5, 28, 8, 9, 0, 1'b0, 32, 9};
    tbl[1] = '{0, 0, 0, 3, 1, 2, 0, 1'b0, 16, 5};
    tbl[2] = '{1, 1, 2, 31, 31, 15, 10, 1'b1, 16, 6};
    tbl[3] = '{3, 3, 1, 0, 5, 0, 2, 1'b0, 48, 5};

    START = 1'b1;
    repeat (3) @(negedge CLK_IN);
    check("rst_outputs",
          {DRAIN_B, PHASE_SEL, DUTY_SEL, READOUT_REQ,
           SUBFRAME_IDX, BUSY, FRAME_DONE}, 0);
    START = 1'b0;
    RST_B = 1'b1;
    @(negedge CLK_IN);
    check("idle_busy", BUSY, 0);

`ifdef SEQ_CONTINUOUS_EN
    cv = '{0, 1, 1, 4, 0, 6, 0, 1'b0, 16, 5};
    apply_cfg(cv);
    START = 1'b1;
    @(negedge CLK_IN);
    START = 1'b0;
    PHASE_BASE = 5'd20;
    dones = 0; drops = 0; ph2 = 0;
    for (int i = 0; i < 400 && dones < 2; i++) begin
      @(negedge CLK_IN);
      READOUT_ACK = READOUT_REQ;
      if (!BUSY) drops++;
      if (FRAME_DONE) begin
        dones++;
        if (dones == 1) ph2 = int'(PHASE_SEL);
      end
    end
    READOUT_ACK = 1'b0;
    check("cont_dones", dones, 2);
    check("cont_busy_drop", drops, 0);
    check("cont_new_base", ph2, 20);
    ABORT = 1'b1;
    @(negedge CLK_IN);
    ABORT = 1'b0;
    check("cont_abort_busy", BUSY, 0);
`else
    for (int i = 0; i < 4; i++) run_frame(tbl[i]);
`endif

    cv = '{0, 2, 1, 12, 0, 5, 0, 1'b0, 0, 0};
    apply_cfg(cv);
    START = 1'b1;
    @(negedge CLK_IN);
    START = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK_IN);
      found = DRAIN_B;
    end
    check("abort_reach_exp", found, 1);
    repeat (3) @(negedge CLK_IN);
    ABORT = 1'b1;
    @(negedge CLK_IN);
    ABORT = 1'b0;
    check("abort_drain_b", DRAIN_B, 0);
    check("abort_busy", BUSY, 0);
    check("abort_req", READOUT_REQ, 0);
    check("abort_done", FRAME_DONE, 0);
    check("abort_phase_hold", PHASE_SEL, 12);
    check("abort_duty_hold", DUTY_SEL, 5);
    viol = 0;
    repeat (40) begin
      @(negedge CLK_IN);
      if (BUSY || FRAME_DONE || DRAIN_B) viol++;
    end
    check("abort_quiet", viol, 0);

    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK_IN);
    START = 1'b0;
    ABORT = 1'b0;
    check("start_abort_busy", BUSY, 0);
    viol = 0;
    repeat (5) begin
      @(negedge CLK_IN);
      if (BUSY) viol++;
    end
    check("start_abort_idle", viol, 0);

    cv = '{1, 2, 3, 7, 1, 9, 0, 1'b0, 0, 0};
    apply_cfg(cv);
    START = 1'b1;
    @(negedge CLK_IN);
    START = 1'b0;
    repeat (15) @(negedge CLK_IN);
    check("pre_rst_phase", PHASE_SEL, 7);
    check("pre_rst_busy", BUSY, 1);
    RST_B = 1'b0;
    @(negedge CLK_IN);
    check("mid_rst_outputs",
          {DRAIN_B, PHASE_SEL, DUTY_SEL, READOUT_REQ,
           SUBFRAME_IDX, BUSY, FRAME_DONE}, 0);
    RST_B = 1'b1;
    @(negedge CLK_IN);
    check("post_rst_busy", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
